piece_drop_ctrl: RTL
====================

PIECE_DROP_CTRL -- requirements
Module: piece_drop_ctrl

Interface
REQ-001 SHALL have parameter STEP_CYCLES, default 2500000, clock cycles per one-row fall step (20 steps/s at 50 MHz); legal range >= 2.
REQ-002 SHALL have port CLK  input  1  system clock; all logic rising-edge.
REQ-003 SHALL have port RST  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port move_valid  input  1  move request present.
REQ-005 SHALL have port move_col  input  3  board column 0..6; 7 is illegal.
REQ-006 SHALL have port move_player  input  1  0 = red, 1 = green.
REQ-007 SHALL have port move_ready  output  1  controller can accept a move.
REQ-008 SHALL have port move_reject  output  1  one-cycle pulse: accepted request was illegal.
REQ-009 SHALL have port drop_done  output  1  one-cycle pulse: piece committed to board.
REQ-010 SHALL have port col_full  output  7  bit c high when column c holds 6 pieces.
REQ-011 SHALL have port RedPixels  output  16x16  red LED array, [row][bit].
REQ-012 SHALL have port GrnPixels  output  16x16  green LED array, [row][bit].

Function
REQ-013 SHALL hold a 7-column x 6-row board; each cell empty, red or green; per-column height 0..6.
REQ-014 SHALL map board row r (0 = top) to pixel row 10+r and board column c to pixel bit 15-c; all other pixels 0.
REQ-015 SHALL drive a red cell as Red=1/Grn=0, a green cell as Red=0/Grn=1, an empty cell as 0/0.
REQ-016 SHALL register RedPixels/GrnPixels; they reflect board and falling piece one cycle after any state change.
REQ-017 SHALL implement FSM states IDLE, FALL, LAND.
REQ-018 IDLE: move_ready=1; a handshake occurs on move_valid & move_ready.
REQ-019 On handshake with move_col=7 or col_full[move_col]=1, SHALL pulse move_reject next cycle, leave the board unchanged and stay in IDLE.
REQ-020 On a legal handshake, SHALL latch col and player, set target = 5 - height[col], cursor = 0, clear the step counter, enter FALL.
REQ-021 FALL: move_ready=0; the falling piece SHALL be displayed at (cursor, col) in the player's colour; move_valid is ignored.
REQ-022 FALL: the step counter SHALL count 0..STEP_CYCLES-1; at terminal count, cursor<target -> cursor+1 and counter cleared; cursor==target -> LAND.
REQ-023 Target 0 (column holds 5 pieces) SHALL still spend exactly STEP_CYCLES cycles in FALL.
REQ-024 LAND (one cycle): SHALL write the cell (target, col), increment height[col], pulse drop_done; next state IDLE.
REQ-025 Total handshake-to-drop_done latency SHALL be (target+1)*STEP_CYCLES + 1 cycles.
REQ-026 col_full SHALL be combinational from heights, updated the cycle after LAND.
REQ-027 move_reject and drop_done SHALL never be high in the same cycle.

Reset
REQ-028 RST SHALL clear all cells and heights, force IDLE, zero the counter, cursor, RedPixels, GrnPixels, move_reject, drop_done; move_ready=1 on the first cycle after RST deasserts.
REQ-029 RST asserted mid-FALL or in LAND SHALL abort the drop with no cell written and no drop_done.

Structure
REQ-030 Package connect4_pkg SHALL hold BOARD_ROWS=6, BOARD_COLS=7, PIX_ROW_BASE=10, PIX_COL_MSB=15, the cell enum (EMPTY, RED, GRN) and the FSM state enum.
REQ-031 The step counter SHALL be a sub-module drop_step_timer (inputs clear, enable; output terminal pulse) parameterised by STEP_CYCLES.

Verification (STEP_CYCLES=4)
REQ-032 RST, then move col 0 red -> Red[15][15]=1 on cycles T+1..T+4 at row 10, down to row 15; drop_done at T+25; final Red[15]=16'h8000, Grn all 0.
REQ-033 Six green moves into col 3 -> heights 1..6, col_full=7'b0001000, sixth drop latency 5 cycles; seventh move into col 3 -> move_reject pulse, board unchanged.
REQ-034 Move with move_col=7 -> move_reject one cycle later, move_ready stays 1, no pixel change.
REQ-035 move_valid held high during FALL with a different column -> ignored until IDLE, then accepted; exactly one drop_done per accepted legal move.
REQ-036 RST asserted at cycle 10 of a drop into empty col 6 -> all pixels 0, col_full=0, no drop_done, move_ready=1 after release.
REQ-037 Alternate red/green into cols 0..6 -> Red[15]=16'hAA00, Grn[15]=16'h5400, rows 0..9 all 0 throughout.

Source files
------------

// File: rtl/connect4_pkg.sv
// Shared board geometry, cell encoding and FSM states for the drop controller.
// Imported by piece_drop_ctrl and drop_step_timer.
package connect4_pkg;

  localparam int BOARD_ROWS   = 6;
  localparam int BOARD_COLS   = 7;
  localparam int PIX_ROW_BASE = 10;
  localparam int PIX_COL_MSB  = 15;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    RED   = 2'd1,
    GRN   = 2'd2
  } cell_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FALL = 2'd1,
    LAND = 2'd2
  } state_t;

  function automatic cell_t player_cell(input logic p);
    return p ? GRN : RED;
  endfunction

endpackage

// File: rtl/drop_step_timer.sv
// Fall-step counter: counts 0..STEP_CYCLES-1 while enabled, wraps on terminal.
// Ports: CLK, RST (sync, high), clear, enable -> terminal (one-cycle pulse).
module drop_step_timer
  import connect4_pkg::*;
#(
  parameter int STEP_CYCLES = 2500000
) (
  input  logic CLK,
  input  logic RST,
  input  logic clear,
  input  logic enable,
  output logic terminal
);

  localparam int CW = (STEP_CYCLES > 2) ? $clog2(STEP_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(STEP_CYCLES - 1);

  logic [CW-1:0] cnt;

  assign terminal = enable && (cnt == LAST);

  always_ff @(posedge CLK) begin
    if (RST || clear) begin
      cnt <= '0;
    end else if (enable) begin
      cnt <= terminal ? '0 : cnt + 1'b1;
    end
  end

endmodule

// File: rtl/piece_drop_ctrl.sv
// Connect-4 piece drop controller: accepts moves, animates the fall, commits cells.
// Ports: CLK, RST, move_valid/col/player/ready/reject, drop_done, col_full, Red/GrnPixels.
module piece_drop_ctrl
  import connect4_pkg::*;
#(
  parameter int STEP_CYCLES = 2500000
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              move_valid,
  input  logic [2:0]        move_col,
  input  logic              move_player,
  output logic              move_ready,
  output logic              move_reject,
  output logic              drop_done,
  output logic [6:0]        col_full,
  output logic [15:0][15:0] RedPixels,
  output logic [15:0][15:0] GrnPixels
);

  state_t state, state_d;

  cell_t      board  [BOARD_ROWS][BOARD_COLS];
  logic [2:0] height [BOARD_COLS];

  logic [2:0] col_q, col_d;
  logic [2:0] tgt_q, tgt_d;
  logic [2:0] cur_q, cur_d;
  logic       ply_q, ply_d;
  logic       reject_q, reject_d;

  logic       wr_en;
  logic       tmr_clr;
  logic       tmr_en;
  logic       step;
  logic [2:0] sel_h;
  logic       legal;

  logic [15:0][15:0] red_d;
  logic [15:0][15:0] grn_d;

  drop_step_timer #(
    .STEP_CYCLES(STEP_CYCLES)
  ) u_timer (
    .CLK     (CLK),
    .RST     (RST),
    .clear   (tmr_clr),
    .enable  (tmr_en),
    .terminal(step)
  );

  assign tmr_en      = (state == FALL);
  assign move_ready  = (state == IDLE) && !RST;
  assign drop_done   = (state == LAND) && !RST;
  assign move_reject = reject_q;

  always_comb begin
    for (int c = 0; c < BOARD_COLS; c++) begin
      col_full[c] = (height[c] == 3'(BOARD_ROWS));
    end
  end

  // Column 7 never matches, so it falls through with sel_h = 0.
  always_comb begin
    sel_h = '0;
    for (int c = 0; c < BOARD_COLS; c++) begin
      if (move_col == 3'(c)) sel_h = height[c];
    end
  end

  assign legal = (move_col != 3'd7) && (sel_h != 3'(BOARD_ROWS));

  always_comb begin
    state_d  = state;
    col_d    = col_q;
    tgt_d    = tgt_q;
    cur_d    = cur_q;
    ply_d    = ply_q;
    reject_d = 1'b0;
    wr_en    = 1'b0;
    tmr_clr  = 1'b0;
    unique case (state)
      IDLE: begin
        if (move_valid) begin
          if (!legal) begin
            reject_d = 1'b1;
          end else begin
            col_d   = move_col;
            ply_d   = move_player;
            tgt_d   = 3'(BOARD_ROWS - 1) - sel_h;
            cur_d   = '0;
            tmr_clr = 1'b1;
            state_d = FALL;
          end
        end
      end
      FALL: begin
        if (step) begin
          if (cur_q == tgt_q) begin
            state_d = LAND;
          end else begin
            cur_d = cur_q + 3'd1;
          end
        end
      end
      LAND: begin
        wr_en   = 1'b1;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Pixels are built from next-cycle values so the registered
  // image matches the board/piece of the cycle it is shown in.
  always_comb begin
    cell_t v;
    v     = EMPTY;
    red_d = '0;
    grn_d = '0;
    for (int r = 0; r < BOARD_ROWS; r++) begin
      for (int c = 0; c < BOARD_COLS; c++) begin
        v = board[r][c];
        if (wr_en && tgt_q == 3'(r) && col_q == 3'(c)) begin
          v = player_cell(ply_q);
        end
        if (v == RED) red_d[PIX_ROW_BASE+r][PIX_COL_MSB-c] = 1'b1;
        if (v == GRN) grn_d[PIX_ROW_BASE+r][PIX_COL_MSB-c] = 1'b1;
      end
    end
    if (state_d == FALL || state_d == LAND) begin
      for (int r = 0; r < BOARD_ROWS; r++) begin
        for (int c = 0; c < BOARD_COLS; c++) begin
          if (cur_d == 3'(r) && col_d == 3'(c)) begin
            if (ply_d) grn_d[PIX_ROW_BASE+r][PIX_COL_MSB-c] = 1'b1;
            else       red_d[PIX_ROW_BASE+r][PIX_COL_MSB-c] = 1'b1;
          end
        end
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state     <= IDLE;
      col_q     <= '0;
      tgt_q     <= '0;
      cur_q     <= '0;
      ply_q     <= 1'b0;
      reject_q  <= 1'b0;
      RedPixels <= '0;
      GrnPixels <= '0;
      for (int r = 0; r < BOARD_ROWS; r++) begin
        for (int c = 0; c < BOARD_COLS; c++) begin
          board[r][c] <= EMPTY;
        end
      end
      for (int c = 0; c < BOARD_COLS; c++) begin
        height[c] <= '0;
      end
    end else begin
      state     <= state_d;
      col_q     <= col_d;
      tgt_q     <= tgt_d;
      cur_q     <= cur_d;
      ply_q     <= ply_d;
      reject_q  <= reject_d;
      RedPixels <= red_d;
      GrnPixels <= grn_d;
      if (wr_en) begin
        for (int c = 0; c < BOARD_COLS; c++) begin
          if (col_q == 3'(c)) begin
            height[c] <= height[c] + 3'd1;
            for (int r = 0; r < BOARD_ROWS; r++) begin
              if (tgt_q == 3'(r)) board[r][c] <= player_cell(ply_q);
            end
          end
        end
      end
    end
  end

endmodule
